// File: rtl/dense_axis_tx.sv
// Buffers N_OUT dense-layer results, then streams them as one AXI-Stream frame; first beat valid the cycle after the final write.
// Holds tdata/tlast while tready is low; writes arriving during SEND are dropped and flagged (ovf). DENSE_AXIS_TX_ARGMAX_EN appends an argmax beat.
module dense_axis_tx #(
    parameter int DATA_W = 32,
    parameter int N_OUT  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              buf_wr,
    input  logic [DATA_W-1:0] buf_wdata,
    input  logic              buf_clr,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              ovf
);
    localparam int IDX_W = $clog2(N_OUT + 1);
`ifdef DENSE_AXIS_TX_ARGMAX_EN
    localparam int N_BEATS = N_OUT + 1;
`else
    localparam int N_BEATS = N_OUT;
`endif
    localparam logic [IDX_W-1:0] WP_LAST = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W-1:0] RP_LAST = IDX_W'(N_BEATS - 1);
    localparam logic [IDX_W-1:0] N_OUT_I = IDX_W'(N_OUT);

    typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_buf [N_OUT];
    logic [IDX_W-1:0]  r_wp;
    logic [IDX_W-1:0]  r_rp;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tvalid;
    logic              r_tlast;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;

    logic              w_wr;
    logic              w_accept;
    logic              w_final;
    logic [IDX_W-1:0]  w_rp_nxt;
    logic [DATA_W-1:0] w_nxt_dat;

    // A clear in the same cycle as a write wins, so the write never lands.
    assign w_wr     = (r_state == FILL) && buf_wr && !buf_clr;
    assign w_accept = r_tvalid && m_axis_tready;
    assign w_final  = w_accept && (r_rp == RP_LAST);
    assign w_rp_nxt = r_rp + 1'b1;

`ifdef DENSE_AXIS_TX_ARGMAX_EN
    logic signed [DATA_W-1:0] r_amax;
    logic [IDX_W-1:0]         r_amax_idx;

    // Strict greater-than keeps the lowest index on ties; wp==0 seeds the tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amax     <= '0;
            r_amax_idx <= '0;
        end else if ((r_state == FILL && buf_clr) || w_final) begin
            r_amax     <= '0;
            r_amax_idx <= '0;
        end else if (w_wr && (r_wp == '0 || $signed(buf_wdata) > r_amax)) begin
            r_amax     <= $signed(buf_wdata);
            r_amax_idx <= r_wp;
        end
    end
`endif

    always_comb begin
        w_nxt_dat = '0;
        if (w_rp_nxt < N_OUT_I) begin
            w_nxt_dat = r_buf[w_rp_nxt];
        end
`ifdef DENSE_AXIS_TX_ARGMAX_EN
        else begin
            w_nxt_dat = DATA_W'(r_amax_idx);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_wp] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FILL;
            r_wp     <= '0;
            r_rp     <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FILL: begin
                    if (buf_clr) begin
                        r_wp  <= '0;
                        r_ovf <= 1'b0;
                    end else if (buf_wr) begin
                        r_wp <= r_wp + 1'b1;
                        if (r_wp == WP_LAST) begin
                            // Entry 0 is already written since N_OUT >= 2.
                            r_state  <= SEND;
                            r_rp     <= '0;
                            r_tdata  <= r_buf[0];
                            r_tvalid <= 1'b1;
                            r_tlast  <= 1'b0;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (buf_wr) begin
                        r_ovf <= 1'b1;
                    end
                    if (w_final) begin
                        r_state  <= FILL;
                        r_wp     <= '0;
                        r_tvalid <= 1'b0;
                        r_tlast  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_accept) begin
                        r_rp    <= w_rp_nxt;
                        r_tdata <= w_nxt_dat;
                        r_tlast <= (w_rp_nxt == RP_LAST);
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign tx_busy       = r_busy;
    assign tx_done       = r_done;
    assign ovf           = r_ovf;
endmodule

// File: tb/tb_dense_axis_tx.sv
// Randomized bench for dense_axis_tx: expected frames come from a plain array model of the buffered words
// (plus argmax index when DENSE_AXIS_TX_ARGMAX_EN is defined).
module tb_dense_axis_tx;
    localparam int DATA_W = 32;
    localparam int N_OUT  = 10;
`ifdef DENSE_AXIS_TX_ARGMAX_EN
    localparam int N_BEATS = N_OUT + 1;
`else
    localparam int N_BEATS = N_OUT;
`endif

    typedef logic [DATA_W-1:0] vals_t  [N_OUT];
    typedef logic [DATA_W-1:0] frame_t [N_BEATS];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              buf_wr = 1'b0;
    logic [DATA_W-1:0] buf_wdata = '0;
    logic              buf_clr = 1'b0;
    logic              m_axis_tready = 1'b0;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              tx_busy;
    logic              tx_done;
    logic              ovf;

    dense_axis_tx #(.DATA_W(DATA_W), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .buf_wr(buf_wr), .buf_wdata(buf_wdata), .buf_clr(buf_clr),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .tx_busy(tx_busy), .tx_done(tx_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] cap_dat [$];
    bit                cap_last [$];
    int                cap_cyc [$];
    int                done_cyc [$];

    // p_*: outputs seen at the latest negedge; s_*: the sample before it plus the tready applied to it
    logic              p_vld = 1'b0, p_last = 1'b0;
    logic [DATA_W-1:0] p_dat = '0;
    logic              s_vld = 1'b0, s_last = 1'b0, s_rdy = 1'b0;
    logic [DATA_W-1:0] s_dat = '0;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (p_vld && m_axis_tready) begin
            cap_dat.push_back(p_dat);
            cap_last.push_back(p_last);
            cap_cyc.push_back(cyc);
        end
        s_vld = p_vld; s_dat = p_dat; s_last = p_last; s_rdy = m_axis_tready;
        p_vld = m_axis_tvalid; p_dat = m_axis_tdata; p_last = m_axis_tlast;
        if (tx_done) done_cyc.push_back(cyc);
    endtask

    task automatic clear_caps();
        cap_dat.delete(); cap_last.delete(); cap_cyc.delete(); done_cyc.delete();
    endtask

    task automatic send_words(input vals_t v, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            buf_wr = 1'b1;
            buf_wdata = v[i];
            m_axis_tready = 1'($urandom_range(0, 1));
            tick();
        end
        buf_wr = 1'b0;
    endtask

    task automatic drain(input bit rnd, output bit timeout);
        int n0;
        n0 = done_cyc.size();
        timeout = 1'b1;
        for (int k = 0; k < 300; k++) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (done_cyc.size() != n0) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    function automatic void rand_vals(output vals_t v);
        for (int i = 0; i < N_OUT; i++) v[i] = $urandom;
    endfunction

    // Frame = the words in write order, optionally followed by the index of the first maximum.
    function automatic void model(input vals_t v, output frame_t e);
        for (int i = 0; i < N_OUT; i++) e[i] = v[i];
`ifdef DENSE_AXIS_TX_ARGMAX_EN
        begin
            int best;
            best = 0;
            for (int i = 1; i < N_OUT; i++)
                if ($signed(v[i]) > $signed(v[best])) best = i;
            e[N_OUT] = DATA_W'(best);
        end
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        vals_t v; frame_t e; bit to;
        for (int i = 0; i < N_OUT; i++) v[i] = DATA_W'(i);
        model(v, e);
        clear_caps();
        send_words(v, 0, N_OUT);
        checks++; if (tx_busy !== 1'b1 || p_vld !== 1'b1) begin errors++; $display("FAIL seq_enter_send busy %b vld %b want 1 1", tx_busy, p_vld); end
        drain(1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL seq_timeout got no tx_done want tx_done"); end
        checks++; if (cap_dat.size() != N_BEATS) begin errors++; $display("FAIL seq_count got %0d want %0d", cap_dat.size(), N_BEATS); end
        for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
            checks++;
            if (cap_dat[i] !== e[i] || cap_last[i] !== (i == N_BEATS - 1)) begin
                errors++; $display("FAIL seq_beat%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], e[i], (i == N_BEATS - 1));
            end
            if (i > 0) begin
                checks++; if (cap_cyc[i] - cap_cyc[i-1] != 1) begin errors++; $display("FAIL seq_gap%0d got %0d want 1", i, cap_cyc[i] - cap_cyc[i-1]); end
            end
        end
        checks++;
        if (done_cyc.size() != 1 || cap_cyc.size() == 0 || done_cyc[0] != cap_cyc[cap_cyc.size()-1]) begin
            errors++; $display("FAIL seq_done_pulse got %0d pulses want 1 aligned to last beat", done_cyc.size());
        end
        tick();
        checks++; if (tx_done !== 1'b0 || m_axis_tvalid !== 1'b0 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL seq_idle done %b vld %b busy %b want 0 0 0", tx_done, m_axis_tvalid, tx_busy);
        end
    endtask

    task automatic test_fixed_vectors();
        vals_t v; frame_t e; bit to;
        int init [N_OUT] = '{-5, 3, 7, 7, -1, 0, 2, 1, 4, 6};
        for (int i = 0; i < N_OUT; i++) v[i] = DATA_W'(init[i]);
        model(v, e);
        clear_caps();
        send_words(v, 0, N_OUT);
        drain(1'b0, to);
        checks++; if (to || cap_dat.size() != N_BEATS) begin errors++; $display("FAIL fixed_count got %0d want %0d", cap_dat.size(), N_BEATS); end
        for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
            checks++;
            if (cap_dat[i] !== e[i] || cap_last[i] !== (i == N_BEATS - 1)) begin
                errors++; $display("FAIL fixed_beat%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], e[i], (i == N_BEATS - 1));
            end
        end
`ifdef DENSE_AXIS_TX_ARGMAX_EN
        checks++; if (cap_dat.size() != N_BEATS || cap_dat[N_OUT] !== 32'd2) begin errors++; $display("FAIL fixed_argmax got %h want 2", (cap_dat.size() == N_BEATS) ? cap_dat[N_OUT] : 'x); end
`endif
    endtask

    task automatic test_stall();
        vals_t v; frame_t e; bit got_done;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        rand_vals(v);
        model(v, e);
        clear_caps();
        send_words(v, 0, N_OUT);
        got_done = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            m_axis_tready = pat[k % 4];
            tick();
            if (s_vld && !s_rdy) begin
                checks++;
                if (p_vld !== 1'b1 || p_dat !== s_dat || p_last !== s_last) begin
                    errors++; $display("FAIL stall_hold cyc %0d got %b/%h/%b want 1/%h/%b", cyc, p_vld, p_dat, p_last, s_dat, s_last);
                end
            end
            got_done = (done_cyc.size() != 0);
        end
        checks++; if (!got_done || cap_dat.size() != N_BEATS) begin errors++; $display("FAIL stall_count got %0d want %0d", cap_dat.size(), N_BEATS); end
        for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
            checks++;
            if (cap_dat[i] !== e[i] || cap_last[i] !== (i == N_BEATS - 1)) begin
                errors++; $display("FAIL stall_beat%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], e[i], (i == N_BEATS - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        vals_t v; frame_t e; bit to;
        for (int f = 0; f < 3; f++) begin
            rand_vals(v);
            model(v, e);
            clear_caps();
            send_words(v, 0, N_OUT);
            drain(1'b1, to);
            checks++; if (to || cap_dat.size() != N_BEATS) begin errors++; $display("FAIL b2b%0d_count got %0d want %0d", f, cap_dat.size(), N_BEATS); end
            for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
                checks++;
                if (cap_dat[i] !== e[i] || cap_last[i] !== (i == N_BEATS - 1)) begin
                    errors++; $display("FAIL b2b%0d_beat%0d got %h/%b want %h/%b", f, i, cap_dat[i], cap_last[i], e[i], (i == N_BEATS - 1));
                end
            end
        end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b want 0", ovf); end
    endtask

    task automatic test_clear();
        vals_t junk, v; frame_t e; bit to;
        rand_vals(junk);
        for (int i = 0; i < N_OUT; i++) v[i] = DATA_W'(100 + i);
        model(v, e);
        clear_caps();
        send_words(junk, 0, 4);
        buf_clr = 1'b1; buf_wr = 1'b1; buf_wdata = junk[5];
        tick();
        buf_clr = 1'b0; buf_wr = 1'b0;
        send_words(v, 0, N_OUT - 1);
        checks++; if (p_vld !== 1'b0 || cap_dat.size() != 0) begin errors++; $display("FAIL clear_early_send got vld %b beats %0d want 0 0", p_vld, cap_dat.size()); end
        send_words(v, N_OUT - 1, N_OUT);
        drain(1'b1, to);
        checks++; if (to || cap_dat.size() != N_BEATS) begin errors++; $display("FAIL clear_count got %0d want %0d", cap_dat.size(), N_BEATS); end
        for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
            checks++;
            if (cap_dat[i] !== e[i] || cap_last[i] !== (i == N_BEATS - 1)) begin
                errors++; $display("FAIL clear_beat%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], e[i], (i == N_BEATS - 1));
            end
        end
    endtask

    task automatic test_ovf();
        vals_t v; frame_t e; bit to;
        rand_vals(v);
        model(v, e);
        clear_caps();
        send_words(v, 0, N_OUT);
        m_axis_tready = 1'b0;
        buf_wr = 1'b1; buf_wdata = ~v[0]; buf_clr = 1'b1;
        tick();
        buf_clr = 1'b0; buf_wdata = ~v[1];
        tick();
        buf_wr = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
        checks++; if (p_vld !== 1'b1 || p_dat !== e[0]) begin errors++; $display("FAIL ovf_hold got %b/%h want 1/%h", p_vld, p_dat, e[0]); end
        drain(1'b1, to);
        checks++; if (to || cap_dat.size() != N_BEATS) begin errors++; $display("FAIL ovf_count got %0d want %0d", cap_dat.size(), N_BEATS); end
        for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
            checks++;
            if (cap_dat[i] !== e[i]) begin errors++; $display("FAIL ovf_beat%0d got %h want %h", i, cap_dat[i], e[i]); end
        end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
        buf_clr = 1'b1;
        tick();
        buf_clr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
    endtask

    task automatic test_reset_mid();
        vals_t v, v2; frame_t e; bit to;
        rand_vals(v);
        rand_vals(v2);
        model(v2, e);
        clear_caps();
        send_words(v, 0, N_OUT);
        for (int k = 0; k < 50 && cap_dat.size() < 5; k++) begin
            m_axis_tready = 1'b1;
            tick();
        end
        checks++; if (cap_dat.size() != 5) begin errors++; $display("FAIL rstmid_reach got %0d beats want 5", cap_dat.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_drop got vld %b busy %b want 0 0", m_axis_tvalid, tx_busy); end
        p_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_caps();
        send_words(v2, 0, N_OUT - 1);
        checks++; if (p_vld !== 1'b0 || cap_dat.size() != 0) begin errors++; $display("FAIL rstmid_early got vld %b beats %0d want 0 0", p_vld, cap_dat.size()); end
        send_words(v2, N_OUT - 1, N_OUT);
        drain(1'b0, to);
        checks++; if (to || cap_dat.size() != N_BEATS) begin errors++; $display("FAIL rstmid_count got %0d want %0d", cap_dat.size(), N_BEATS); end
        for (int i = 0; i < cap_dat.size() && i < N_BEATS; i++) begin
            checks++;
            if (cap_dat[i] !== e[i] || cap_last[i] !== (i == N_BEATS - 1)) begin
                errors++; $display("FAIL rstmid_beat%0d got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], e[i], (i == N_BEATS - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_fixed_vectors();
        test_stall();
        test_back_to_back();
        test_clear();
        test_ovf();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
